// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file write-port arbiter.
// Holds default widths, the arbiter state enum and a modulo index helper.
package regfile_pkg;

   localparam int DEF_WORD_SIZE = 16;
   localparam int DEF_ADDR_SIZE = 3;
   localparam int DEF_NUM_REQ   = 4;

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } arbState_t;

   // Requester index reached by stepping 'offset' places from 'base', wrapping at n.
   function automatic int wrapIdx(input int base, input int offset, input int n);
      return (base + offset) % n;
   endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: requester handshake, clear control and register-file write bus.
// master = requesters/software side, slave = the arbiter.
interface regfile_wr_arbiter_if
   import regfile_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE,
   parameter int NUM_REQ   = DEF_NUM_REQ
);

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
   logic [NUM_REQ*WORD_SIZE-1:0] req_data;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         clear_start;
   logic                         clear_busy;
   logic                         clear_done;
   logic [ADDR_SIZE-1:0]         wrtAddr;
   logic [WORD_SIZE-1:0]         wrtData;
   logic                         wrtEnable;

   modport master (
      output req_valid, req_addr, req_data, clear_start,
      input  req_ready, clear_busy, clear_done, wrtAddr, wrtData, wrtEnable
   );

   modport slave (
      input  req_valid, req_addr, req_data, clear_start,
      output req_ready, clear_busy, clear_done, wrtAddr, wrtData, wrtEnable
   );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick, searching upward from ptr.
// Produces a one-hot grant and the binary winner index; all zero when disabled.
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   winner
);

   logic [IDX_W-1:0] idx;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      grant  = '0;
      winner = '0;
      idx    = '0;
      if (en) begin
         // Walk from the farthest offset down so the nearest requester overwrites last.
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'(wrapIdx(int'(ptr), k, NUM_REQ));
            if (req[idx]) begin
               grant      = '0;
               grant[idx] = 1'b1;
               winner     = idx;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin sharing of the register file's single write port.
// `define REGFILE_WR_ARB_CLEAR_EN adds the zero-sweep clear sequencer (CLEAR state).
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE,
   parameter int NUM_REQ   = DEF_NUM_REQ
) (
   input  logic                clk,
   input  logic                rst,
   regfile_wr_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]     ptr, ptrNext, winner;
   logic [NUM_REQ-1:0]   grant;
   logic                 arbEn, xfer;
   logic                 wrtEnableQ, wrtEnableNext;
   logic [ADDR_SIZE-1:0] wrtAddrQ, wrtAddrNext;
   logic [WORD_SIZE-1:0] wrtDataQ, wrtDataNext;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
      .req    (bus.req_valid),
      .ptr    (ptr),
      .en     (arbEn),
      .grant  (grant),
      .winner (winner)
   );

   assign bus.req_ready = grant;
   assign xfer          = |grant;
   assign bus.wrtEnable = wrtEnableQ;
   assign bus.wrtAddr   = wrtAddrQ;
   assign bus.wrtData   = wrtDataQ;

`ifdef REGFILE_WR_ARB_CLEAR_EN
   arbState_t            state, nextState;
   logic [ADDR_SIZE-1:0] cnt, cntNext;
   logic                 clearDoneQ, clearDoneNext;

   // A clear request blocks grants in the very cycle it is raised.
   assign arbEn          = (state == ARB) && !bus.clear_start;
   assign bus.clear_busy = (state == CLEAR);
   assign bus.clear_done = clearDoneQ;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ARB;
      else     state <= nextState;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         clearDoneQ <= 1'b0;
      end else begin
         cnt        <= cntNext;
         clearDoneQ <= clearDoneNext;
      end
   end
`else
   logic unusedClearStart;

   assign unusedClearStart = bus.clear_start;
   assign arbEn            = 1'b1;
   assign bus.clear_busy   = 1'b0;
   assign bus.clear_done   = 1'b0;
`endif

   always_comb begin
      wrtEnableNext = 1'b0;
      wrtAddrNext   = wrtAddrQ;
      wrtDataNext   = wrtDataQ;
      ptrNext       = ptr;
      if (xfer) begin
         wrtEnableNext = 1'b1;
         wrtAddrNext   = bus.req_addr[int'(winner)*ADDR_SIZE +: ADDR_SIZE];
         wrtDataNext   = bus.req_data[int'(winner)*WORD_SIZE +: WORD_SIZE];
         ptrNext       = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
`ifdef REGFILE_WR_ARB_CLEAR_EN
      nextState     = state;
      cntNext       = cnt;
      clearDoneNext = 1'b0;
      unique case (state)
         ARB: begin
            // cnt always mirrors the address presented during the sweep.
            if (bus.clear_start) begin
               nextState     = CLEAR;
               cntNext       = '0;
               wrtEnableNext = 1'b1;
               wrtAddrNext   = '0;
               wrtDataNext   = '0;
            end
         end
         CLEAR: begin
            if (&cnt) begin
               nextState     = ARB;
               cntNext       = '0;
               clearDoneNext = 1'b1;
            end else begin
               cntNext       = cnt + 1'b1;
               wrtEnableNext = 1'b1;
               wrtAddrNext   = cnt + 1'b1;
               wrtDataNext   = '0;
            end
         end
         default: nextState = ARB;
      endcase
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr        <= '0;
         wrtEnableQ <= 1'b0;
         wrtAddrQ   <= '0;
         wrtDataQ   <= '0;
      end else begin
         ptr        <= ptrNext;
         wrtEnableQ <= wrtEnableNext;
         wrtAddrQ   <= wrtAddrNext;
         wrtDataQ   <= wrtDataNext;
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: table vectors, directed clear/reset sequences and a randomized
// run against a queue-based reference model; covers both REGFILE_WR_ARB_CLEAR_EN builds.
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   localparam int WS = 16;
   localparam int AS = 3;
   localparam int NR = 4;
   localparam int RM = 2**AS;
`ifdef REGFILE_WR_ARB_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   typedef struct {
      logic [NR-1:0] valid;
      logic [NR-1:0] expReady;
   } vec_t;

   typedef struct packed {
      logic          en;
      logic [AS-1:0] addr;
      logic [WS-1:0] data;
      logic          busy;
      logic          done;
   } outs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   regfile_wr_arbiter_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .NUM_REQ(NR)) bus ();

   regfile_wr_arbiter #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .NUM_REQ(NR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [AS-1:0] pa [NR];
   logic [WS-1:0] pd [NR];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkOut(input string tag, input logic en, input logic [AS-1:0] a,
                           input logic [WS-1:0] d, input logic busy, input logic done);
      check({tag, ".wrtEnable"}, 32'(bus.wrtEnable), 32'(en));
      check({tag, ".wrtAddr"}, 32'(bus.wrtAddr), 32'(a));
      check({tag, ".wrtData"}, 32'(bus.wrtData), 32'(d));
      check({tag, ".clear_busy"}, 32'(bus.clear_busy), 32'(busy));
      check({tag, ".clear_done"}, 32'(bus.clear_done), 32'(done));
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drivePayload();
      for (int i = 0; i < NR; i++) begin
         bus.req_addr[i*AS +: AS] = pa[i];
         bus.req_data[i*WS +: WS] = pd[i];
      end
   endtask

   function automatic logic [AS-1:0] payAddr(input int seed, input int i);
      return AS'((i * 3 + seed) % RM);
   endfunction

   function automatic logic [WS-1:0] payData(input int seed, input int i);
      return WS'(32'hA000 + seed * 16 + i);
   endfunction

   task automatic setPayload(input int seed);
      for (int i = 0; i < NR; i++) begin
         pa[i] = payAddr(seed, i);
         pd[i] = payData(seed, i);
      end
      drivePayload();
   endtask

   task automatic applyReset();
      @(posedge clk);
      #1;
      rst             = 1'b1;
      bus.req_valid   = '0;
      bus.clear_start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Reference model state for the randomized run.
   int            mPtr;
   logic          mEn, mBusy, mDone;
   logic [AS-1:0] mAddr;
   logic [WS-1:0] mData;
   outs_t         pend [$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t          vecs [16];
      logic          prevEn;
      logic [AS-1:0] prevAddr;
      logic [WS-1:0] prevData;
      logic [NR-1:0] v, expR;
      logic          cs;
      int            win;
      outs_t         o;

      vecs[0]  = '{4'b1111, 4'b0001};
      vecs[1]  = '{4'b1111, 4'b0010};
      vecs[2]  = '{4'b1111, 4'b0100};
      vecs[3]  = '{4'b1111, 4'b1000};
      vecs[4]  = '{4'b1111, 4'b0001};
      vecs[5]  = '{4'b1111, 4'b0010};
      vecs[6]  = '{4'b1111, 4'b0100};
      vecs[7]  = '{4'b1111, 4'b1000};
      vecs[8]  = '{4'b0000, 4'b0000};
      vecs[9]  = '{4'b0010, 4'b0010};
      vecs[10] = '{4'b1010, 4'b1000};
      vecs[11] = '{4'b1010, 4'b0010};
      vecs[12] = '{4'b1010, 4'b1000};
      vecs[13] = '{4'b1010, 4'b0010};
      vecs[14] = '{4'b0001, 4'b0001};
      vecs[15] = '{4'b1000, 4'b1000};

      bus.req_valid   = '0;
      bus.clear_start = 1'b0;
      setPayload(0);

      // Reset state.
      #2;
      checkOut("reset", 1'b0, '0, '0, 1'b0, 1'b0);
      check("reset.ready", 32'(bus.req_ready), 32'h0);

      // Single write from requester 2.
      applyReset();
      setPayload(0);
      pa[2] = 3'd5;
      pd[2] = 16'hBEEF;
      drivePayload();
      bus.req_valid = 4'b0100;
      #3;
      check("single.ready", 32'(bus.req_ready), 32'b0100);
      checkOut("single.pre", 1'b0, '0, '0, 1'b0, 1'b0);
      nextCycle();
      bus.req_valid = '0;
      #3;
      check("single.idleReady", 32'(bus.req_ready), 32'h0);
      checkOut("single.wr", 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b0);
      nextCycle();
      #3;
      checkOut("single.hold", 1'b0, 3'd5, 16'hBEEF, 1'b0, 1'b0);

      // Table: round-robin from reset, idle hold, and the fairness skip (ptr=2, requesters 1 and 3).
      applyReset();
      prevEn   = 1'b0;
      prevAddr = '0;
      prevData = '0;
      for (int r = 0; r < 16; r++) begin
         setPayload(r);
         bus.req_valid = vecs[r].valid;
         #3;
         check($sformatf("vec%0d.ready", r), 32'(bus.req_ready), 32'(vecs[r].expReady));
         checkOut($sformatf("vec%0d", r), prevEn, prevAddr, prevData, 1'b0, 1'b0);
         prevEn = 1'b0;
         for (int i = 0; i < NR; i++) begin
            if (vecs[r].expReady[i]) begin
               prevEn   = 1'b1;
               prevAddr = payAddr(r, i);
               prevData = payData(r, i);
            end
         end
         nextCycle();
      end
      bus.req_valid = '0;
      #3;
      checkOut("vec.tail", prevEn, prevAddr, prevData, 1'b0, 1'b0);

`ifdef REGFILE_WR_ARB_CLEAR_EN
      // Clear with contention: one transfer leaves ptr=2, then clear while all are valid.
      applyReset();
      setPayload(20);
      bus.req_valid = 4'b0010;
      #3;
      check("clr.setup.ready", 32'(bus.req_ready), 32'b0010);
      nextCycle();
      bus.req_valid   = '1;
      bus.clear_start = 1'b1;
      #3;
      check("clr.start.ready", 32'(bus.req_ready), 32'h0);
      nextCycle();
      bus.clear_start = 1'b0;
      for (int k = 1; k <= RM; k++) begin
         // A second clear_start mid-sweep must be ignored.
         bus.clear_start = (k == 3);
         #3;
         check($sformatf("clr.c%0d.ready", k), 32'(bus.req_ready), 32'h0);
         checkOut($sformatf("clr.c%0d", k), 1'b1, AS'(k - 1), '0, 1'b1, 1'b0);
         nextCycle();
      end
      bus.clear_start = 1'b0;
      #3;
      check("clr.done.ready", 32'(bus.req_ready), 32'b0100);
      checkOut("clr.done", 1'b0, AS'(RM - 1), '0, 1'b0, 1'b1);
      nextCycle();
      #3;
      check("clr.after.ready", 32'(bus.req_ready), 32'b1000);
      checkOut("clr.after", 1'b1, payAddr(20, 2), payData(20, 2), 1'b0, 1'b0);

      // Reset during the write to address 3.
      applyReset();
      bus.req_valid   = '1;
      bus.clear_start = 1'b1;
      nextCycle();
      bus.clear_start = 1'b0;
      for (int k = 0; k < 3; k++) nextCycle();
      #2;
      checkOut("rstclr.pre", 1'b1, 3'd3, '0, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      checkOut("rstclr.async", 1'b0, '0, '0, 1'b0, 1'b0);
      nextCycle();
      rst = 1'b0;
      for (int k = 0; k < NR; k++) begin
         #3;
         check($sformatf("rstclr.g%0d.ready", k), 32'(bus.req_ready), 32'(1 << k));
         check($sformatf("rstclr.g%0d.busy", k), 32'(bus.clear_busy), 32'h0);
         nextCycle();
      end
`else
      // clear_start has no effect in this build.
      applyReset();
      setPayload(30);
      bus.req_valid   = 4'b0001;
      bus.clear_start = 1'b1;
      #3;
      check("noclr.ready", 32'(bus.req_ready), 32'b0001);
      checkOut("noclr.pre", 1'b0, '0, '0, 1'b0, 1'b0);
      nextCycle();
      bus.clear_start = 1'b0;
      #3;
      check("noclr.ready2", 32'(bus.req_ready), 32'b0001);
      checkOut("noclr.wr", 1'b1, payAddr(30, 0), payData(30, 0), 1'b0, 1'b0);
      nextCycle();
      #2;
      checkOut("noclr.wr2", 1'b1, payAddr(30, 0), payData(30, 0), 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      checkOut("noclr.async", 1'b0, '0, '0, 1'b0, 1'b0);
      nextCycle();
      rst = 1'b0;
`endif

      // Randomized run against the reference model.
      applyReset();
      mPtr  = 0;
      mEn   = 1'b0;
      mAddr = '0;
      mData = '0;
      mBusy = 1'b0;
      mDone = 1'b0;
      pend.delete();
      for (int c = 0; c < 400; c++) begin
         v  = NR'($urandom);
         cs = ($urandom_range(0, 15) == 0);
         for (int i = 0; i < NR; i++) begin
            pa[i] = AS'($urandom);
            pd[i] = WS'($urandom);
         end
         drivePayload();
         bus.req_valid   = v;
         bus.clear_start = cs;

         expR = '0;
         win  = -1;
         if (!mBusy && !(CLR_EN && cs)) begin
            for (int k = 0; k < NR; k++) begin
               if (win < 0 && v[(mPtr + k) % NR]) win = (mPtr + k) % NR;
            end
         end
         if (win >= 0) expR[win] = 1'b1;

         #3;
         check($sformatf("rnd%0d.ready", c), 32'(bus.req_ready), 32'(expR));
         checkOut($sformatf("rnd%0d", c), mEn, mAddr, mData, mBusy, mDone);

         if (pend.size() > 0) begin
            o     = pend.pop_front();
            mEn   = o.en;
            mAddr = o.addr;
            mData = o.data;
            mBusy = o.busy;
            mDone = o.done;
         end else if (CLR_EN && cs) begin
            mEn   = 1'b1;
            mAddr = '0;
            mData = '0;
            mBusy = 1'b1;
            mDone = 1'b0;
            for (int a = 1; a < RM; a++) pend.push_back('{1'b1, AS'(a), '0, 1'b1, 1'b0});
            pend.push_back('{1'b0, AS'(RM - 1), '0, 1'b0, 1'b1});
         end else if (win >= 0) begin
            mEn   = 1'b1;
            mAddr = pa[win];
            mData = pd[win];
            mBusy = 1'b0;
            mDone = 1'b0;
            mPtr  = (win + 1) % NR;
         end else begin
            mEn   = 1'b0;
            mBusy = 1'b0;
            mDone = 1'b0;
         end
         nextCycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the register file's single write port among `NUM_REQ` independent requesters using a round-robin arbiter with a valid/ready handshake. It drives the register file's `wrtAddr`/`wrtData`/`wrtEnable` inputs from registered outputs. An optional sequencer sweeps zeros through every register on command, so software can clear the file without asserting the global reset. It sits directly in front of the register file's write port; the read ports are untouched.

## Interface
- `WORD_SIZE`, default 16: data width; must match the register file.
- `ADDR_SIZE`, default 3: register address width; `REG_MAX = 2**ADDR_SIZE`.
- `NUM_REQ`, default 4: number of write requesters, at least 2.
- `clk`  in  1: single clock; all flops on rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  NUM_REQ: per-requester write request.
- `req_addr`  in  NUM_REQ*ADDR_SIZE: packed addresses; requester i occupies bits [i*ADDR_SIZE +: ADDR_SIZE].
- `req_data`  in  NUM_REQ*WORD_SIZE: packed data; requester i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- `req_ready`  out  NUM_REQ: combinational one-hot grant; at most one bit is high.
- `clear_start`  in  1: one-cycle request to zero all registers.
- `clear_busy`  out  1: clear sweep in progress.
- `clear_done`  out  1: one-cycle pulse when the sweep completes.
- `wrtAddr`  out  ADDR_SIZE: to the register file; registered.
- `wrtData`  out  WORD_SIZE: to the register file; registered.
- `wrtEnable`  out  1: to the register file; registered.

## Operation
- States: ARB (the reset state) and CLEAR.
- ARB:
  - Winner = first i with `req_valid[i]`, searching from `ptr` upward modulo `NUM_REQ`.
  - `req_ready[winner]=1`; all other bits are 0.
  - Transfer happens when `req_valid[i] & req_ready[i]`.
  - On a transfer: the next edge loads `wrtEnable=1`, `wrtAddr=req_addr[i]`, `wrtData=req_data[i]`, and sets `ptr` to (i+1) mod `NUM_REQ`.
  - With no transfer, the next edge loads `wrtEnable=0` and `ptr` holds. `wrtAddr`/`wrtData` hold their values.
- One write per cycle; full throughput. A requester holding `req_valid` is granted within `NUM_REQ` cycles.
- `req_ready` never depends on `req_addr` or `req_data`.
- `clear_start` in ARB:
  - Forces `req_ready=0` in that cycle; clear wins over same-cycle requests.
  - Next edge enters CLEAR with counter `cnt=0`.
- CLEAR:
  - Each edge loads `wrtEnable=1`, `wrtAddr=cnt`, `wrtData=0`, then increments `cnt`.
  - After the edge that loads `cnt=REG_MAX-1`, the next edge returns to ARB, loads `wrtEnable=0`, and sets `clear_done=1` for one cycle.
  - `req_ready=0` throughout; `clear_start` is ignored.
- `clear_busy` is high exactly in the cycles where a clear write is presented on the outputs.
- `ptr` is unchanged by a clear.
- Reset (asynchronous, any state, including mid-clear):
  - State=ARB, `ptr=0`, `cnt=0`.
  - `wrtEnable=0`, `wrtAddr=0`, `wrtData=0`, `clear_busy=0`, `clear_done=0`.
  - A sweep interrupted by reset is abandoned, not resumed.

## Timing
- Write latency: transfer in cycle N gives `wrtEnable` in cycle N+1; the register file captures the value at the end of N+1.
- Clear: `clear_start` sampled at edge E0.
  - Cycles 1..REG_MAX after E0: `wrtEnable=1`, `wrtAddr=0..REG_MAX-1`, `clear_busy=1`.
  - Cycle REG_MAX+1: `clear_done=1`, `wrtEnable=0`, and `req_ready` is live again.
  - Total stall seen by requesters: REG_MAX+1 cycles, counting the `clear_start` cycle.
- Combinational paths: only `req_valid`, `clear_start`, and state to `req_ready`.

## Configuration
- Macro `REGFILE_WR_ARB_CLEAR_EN`.
- Defined: the CLEAR state, counter, and `clear_*` behaviour are present as described above.
- Undefined:
  - No CLEAR state and no counter.
  - `clear_start` is ignored and does not block grants.
  - `clear_busy` and `clear_done` are tied to 0.
  - Ports remain, so the interface is identical in both builds.

## Structure
- Shared package `regfile_pkg`: default `WORD_SIZE`/`ADDR_SIZE` constants and the state enum (ARB, CLEAR).
- One sub-module, `rr_arbiter`: purely combinational. Inputs are the `req` vector, `ptr`, and an enable. Outputs are the one-hot grant and the winner index.
- The top level holds the FSM, pointer, counter, and output registers.

## Test plan
- Single write: requester 2 presents `addr=5`, `data=0xBEEF` for one cycle after reset → `req_ready[2]=1` that cycle; next cycle `wrtEnable=1`, `wrtAddr=5`, `wrtData=0xBEEF`.
- Round-robin: all four requesters hold valid for 8 cycles from reset → grants 0,1,2,3,0,1,2,3 with `wrtEnable` high on 8 consecutive cycles.
- Fairness skip: only requesters 1 and 3 valid, `ptr=2` → grant 3 then 1, alternating.
- Clear with contention (macro on, REG_MAX=8): `clear_start` while all requesters are valid → `req_ready=0` for 9 cycles; `wrtAddr` runs 0..7 with data 0; `clear_done` pulses; the next grant goes to the pre-clear `ptr`.
- Reset mid-clear: assert `rst` during the write to address 3 → all outputs 0 immediately; after release, grants resume from requester 0 and `clear_busy` stays 0.
- Macro off: `clear_start` pulsed while requester 0 is valid → grant unaffected; `clear_busy` and `clear_done` remain 0.
